// File: rtl/sensor_scan_if.sv
// Signal bundle between the sensor scan scheduler and its surroundings.
// Latency: none, wires only.
// Backpressure: none. The trigger side uses a hold-until-done handshake (start_trigger/trigger_done).
// Ports: enable, trigger_done and echo_in go into the scheduler. start_trigger, sensor_sel,
//   busy and the meas_* result group come out of it.
interface sensor_scan_if #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W       = 2,
  parameter int CNT_W       = 16
);
  logic                   enable;
  logic                   trigger_done;
  logic [NUM_SENSORS-1:0] echo_in;
  logic                   start_trigger;
  logic [SEL_W-1:0]       sensor_sel;
  logic                   busy;
  logic                   meas_valid;
  logic [SEL_W-1:0]       meas_sensor;
  logic [CNT_W-1:0]       meas_width;
  logic                   meas_timeout;

  // master: the scheduler itself
  modport master (
    input  enable, trigger_done, echo_in,
    output start_trigger, sensor_sel, busy,
    output meas_valid, meas_sensor, meas_width, meas_timeout
  );

  // slave: trigger generator, echo front end and result consumer
  modport slave (
    output enable, trigger_done, echo_in,
    input  start_trigger, sensor_sel, busy,
    input  meas_valid, meas_sensor, meas_width, meas_timeout
  );
endinterface

// File: rtl/sensor_scan_scheduler.sv
// Round-robin ultrasonic scan. It fires the shared trigger generator for one sensor, then times
//   that sensor's echo. It emits one width-or-timeout result per sensor and then waits out a
//   ring-down holdoff before moving to the next sensor.
// Latency: an echo edge is seen 2 cycles after the raw line moves, because of the synchroniser.
//   The result strobe comes 1 cycle after the edge or timeout is detected.
// Backpressure: none. Results are one-cycle strobes. start_trigger is held until trigger_done.
// Ports: clk, reset_n (async, active low), bus (sensor_scan_if.master).
module sensor_scan_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int SEL_W          = 2,
  parameter int CNT_W          = 16,
  parameter int ECHO_TIMEOUT   = 30000,
  parameter int HOLDOFF_CYCLES = 500
) (
  input  logic          clk,
  input  logic          reset_n,
  sensor_scan_if.master bus
);

  localparam int               HOLD_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [SEL_W-1:0]  PTR_LAST   = SEL_W'(NUM_SENSORS - 1);
  localparam logic [CNT_W-1:0]  WIDTH_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              meas_valid_q, meas_valid_d;
  logic [SEL_W-1:0]  meas_sensor_q, meas_sensor_d;
  logic [CNT_W-1:0]  meas_width_q, meas_width_d;
  logic              meas_timeout_q, meas_timeout_d;

  // Two-flop synchroniser on the selected echo line, plus one more flop for edge detection.
  // echo_prev_q follows the synced level in every state. A line that is already high when
  // WAIT_RISE starts therefore gives no rising edge, so ring-down from the burst is ignored.
  logic echo_s1_q, echo_s2_q, echo_prev_q;
  logic echo_rise, echo_fall;
  logic [CNT_W-1:0] width_inc;

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;
  assign width_inc = (width_q == WIDTH_MAX) ? width_q : width_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      timer_q        <= '0;
      width_q        <= '0;
      hold_q         <= '0;
      meas_valid_q   <= 1'b0;
      meas_sensor_q  <= '0;
      meas_width_q   <= '0;
      meas_timeout_q <= 1'b0;
      echo_s1_q      <= 1'b0;
      echo_s2_q      <= 1'b0;
      echo_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      timer_q        <= timer_d;
      width_q        <= width_d;
      hold_q         <= hold_d;
      meas_valid_q   <= meas_valid_d;
      meas_sensor_q  <= meas_sensor_d;
      meas_width_q   <= meas_width_d;
      meas_timeout_q <= meas_timeout_d;
      echo_s1_q      <= bus.echo_in[ptr_q];
      echo_s2_q      <= echo_s1_q;
      echo_prev_q    <= echo_s2_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    timer_d        = timer_q;
    width_d        = width_q;
    hold_d         = hold_q;
    meas_valid_d   = 1'b0;
    meas_sensor_d  = meas_sensor_q;
    meas_width_d   = meas_width_q;
    meas_timeout_d = meas_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = TRIG;
      end

      TRIG: begin
        if (bus.trigger_done) begin
          timer_d = '0;
          state_d = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        timer_d = timer_q + CNT_W'(1);
        // The timeout has priority here. An edge seen on the very last cycle would leave no
        // room to measure anything.
        if (timer_q == TIMER_LAST) begin
          meas_valid_d   = 1'b1;
          meas_sensor_d  = ptr_q;
          meas_width_d   = '0;
          meas_timeout_d = 1'b1;
          hold_d         = '0;
          state_d        = HOLDOFF;
        end else if (echo_rise) begin
          width_d = CNT_W'(1);
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        timer_d = timer_q + CNT_W'(1);
        if (echo_fall) begin
          // A falling edge beats a timeout that lands on the same cycle.
          meas_valid_d   = 1'b1;
          meas_sensor_d  = ptr_q;
          meas_width_d   = width_q;
          meas_timeout_d = 1'b0;
          hold_d         = '0;
          state_d        = HOLDOFF;
        end else if (timer_q == TIMER_LAST) begin
          // The echo is still high, so this last cycle counts toward the width.
          meas_valid_d   = 1'b1;
          meas_sensor_d  = ptr_q;
          meas_width_d   = width_inc;
          meas_timeout_d = 1'b1;
          hold_d         = '0;
          state_d        = HOLDOFF;
        end else begin
          width_d = width_inc;
        end
      end

      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
          state_d = bus.enable ? TRIG : IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.start_trigger = (state_q == TRIG);
  assign bus.busy          = (state_q != IDLE);
  assign bus.sensor_sel    = ptr_q;
  assign bus.meas_valid    = meas_valid_q;
  assign bus.meas_sensor   = meas_sensor_q;
  assign bus.meas_width    = meas_width_q;
  assign bus.meas_timeout  = meas_timeout_q;

endmodule
